// File: rtl/anita_multi_deadtime_scaler_if.sv
// rtl/anita_multi_deadtime_scaler_if.sv - dead-level inputs, pps strobe and scaler readback bundle
interface anita_multi_deadtime_scaler_if #(
    parameter int NCH      = 4,
    parameter int OUT_BITS = 16
);
    localparam int AW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0]      dead_i;
    logic [NCH-1:0]      mode_i;
    logic                pps_i;
    logic [AW-1:0]       rd_addr_i;
    logic [OUT_BITS-1:0] scaler_o;
    logic [NCH-1:0]      sat_o;
    logic                pps_done_o;

    modport master (
        output dead_i, mode_i, pps_i, rd_addr_i,
        input  scaler_o, sat_o, pps_done_o
    );

    modport slave (
        input  dead_i, mode_i, pps_i, rd_addr_i,
        output scaler_o, sat_o, pps_done_o
    );
endinterface

// File: rtl/anita_multi_deadtime_scaler.sv
// rtl/anita_multi_deadtime_scaler.sv - per-channel prescaled deadtime accumulators latched on pps
module anita_multi_deadtime_scaler #(
    parameter int NCH           = 4,
    parameter int PRESCALE_BITS = 5,
    parameter int ACC_BITS      = 23,
    parameter int OUT_BITS      = 16,
    parameter int OUT_LSB       = 6
) (
    input  logic                          clk33_i,
    input  logic                          rst_i,
    anita_multi_deadtime_scaler_if.slave  bus
);
    localparam int TOP = OUT_LSB + OUT_BITS;

    if (TOP > ACC_BITS) begin : g_bad_params
        $error("OUT_LSB+OUT_BITS exceeds ACC_BITS");
    end

    // Bits at or above TOP are the ones that force a saturated readout.
    localparam logic [ACC_BITS-1:0] LOW_MASK = {ACC_BITS{1'b1}} >> (ACC_BITS - TOP);

    logic [NCH-1:0]           dead_q;
    logic [NCH-1:0]           qual;
    logic [NCH-1:0]           sat_q, sat_d;
    logic                     armed_q;
    logic                     pps_done_q;
    logic [PRESCALE_BITS-1:0] pre_q    [NCH];
    logic [PRESCALE_BITS-1:0] pre_d    [NCH];
    logic [ACC_BITS-1:0]      acc_q    [NCH];
    logic [ACC_BITS-1:0]      acc_d    [NCH];
    logic [OUT_BITS-1:0]      scaler_q [NCH];
    logic [OUT_BITS-1:0]      scaler_d [NCH];
    logic [OUT_BITS-1:0]      scaler_o_q, scaler_o_d;

    always_comb begin
        for (int n = 0; n < NCH; n++) begin
            // armed_q masks the edge a level already high at reset release would fake.
            qual[n]     = bus.dead_i[n] & (~bus.mode_i[n] | (~dead_q[n] & armed_q));
            pre_d[n]    = pre_q[n];
            acc_d[n]    = acc_q[n];
            scaler_d[n] = scaler_q[n];
            sat_d[n]    = sat_q[n];
            if (bus.pps_i) begin
                pre_d[n] = '0;
                acc_d[n] = '0;
                if (|(acc_q[n] & ~LOW_MASK)) begin
                    scaler_d[n] = '1;
                    sat_d[n]    = 1'b1;
                end else begin
                    scaler_d[n] = acc_q[n][OUT_LSB +: OUT_BITS];
                    sat_d[n]    = 1'b0;
                end
            end else if (qual[n]) begin
                pre_d[n] = pre_q[n] + PRESCALE_BITS'(1);
                if ((&pre_q[n]) && !(&acc_q[n])) begin
                    acc_d[n] = acc_q[n] + ACC_BITS'(1);
                end
            end
        end
        scaler_o_d = '0;
        if (int'(bus.rd_addr_i) < NCH) begin
            scaler_o_d = scaler_q[bus.rd_addr_i];
        end
    end

    always_ff @(posedge clk33_i) begin
        if (rst_i) begin
            dead_q     <= '0;
            armed_q    <= 1'b0;
            pps_done_q <= 1'b0;
            sat_q      <= '0;
            scaler_o_q <= '0;
            for (int n = 0; n < NCH; n++) begin
                pre_q[n]    <= '0;
                acc_q[n]    <= '0;
                scaler_q[n] <= '0;
            end
        end else begin
            dead_q     <= bus.dead_i;
            armed_q    <= 1'b1;
            pps_done_q <= bus.pps_i;
            sat_q      <= sat_d;
            scaler_o_q <= scaler_o_d;
            for (int n = 0; n < NCH; n++) begin
                pre_q[n]    <= pre_d[n];
                acc_q[n]    <= acc_d[n];
                scaler_q[n] <= scaler_d[n];
            end
        end
    end

    assign bus.scaler_o   = scaler_o_q;
    assign bus.sat_o      = sat_q;
    assign bus.pps_done_o = pps_done_q;
endmodule

// File: tb/tb_anita_multi_deadtime_scaler.sv
// tb/tb_anita_multi_deadtime_scaler.sv - vector table, corner sequences and random run against a count model
module tb_anita_multi_deadtime_scaler;
    localparam int NB = 3, PB = 1, AB = 6, LB = 1, OB = 4;

    logic clk = 1'b0;
    logic rst;
    always #15 clk = ~clk;

    logic [3:0] dead_v [2];
    logic [3:0] mode_v [2];
    logic       pps_v  [2];
    int         rd_v   [2];

    anita_multi_deadtime_scaler_if #(.NCH(4),  .OUT_BITS(16)) ifa ();
    anita_multi_deadtime_scaler_if #(.NCH(NB), .OUT_BITS(OB)) ifb ();

    assign ifa.dead_i    = dead_v[0];
    assign ifa.mode_i    = mode_v[0];
    assign ifa.pps_i     = pps_v[0];
    assign ifa.rd_addr_i = 2'(rd_v[0]);
    assign ifb.dead_i    = dead_v[1][2:0];
    assign ifb.mode_i    = mode_v[1][2:0];
    assign ifb.pps_i     = pps_v[1];
    assign ifb.rd_addr_i = 2'(rd_v[1]);

    anita_multi_deadtime_scaler dut_a (.clk33_i(clk), .rst_i(rst), .bus(ifa.slave));
    anita_multi_deadtime_scaler #(
        .NCH(NB), .PRESCALE_BITS(PB), .ACC_BITS(AB), .OUT_BITS(OB), .OUT_LSB(LB)
    ) dut_b (.clk33_i(clk), .rst_i(rst), .bus(ifb.slave));

    int nch  [2] = '{4, NB};
    int pre  [2] = '{5, PB};
    int accb [2] = '{23, AB};
    int lsb  [2] = '{6, LB};
    int ob   [2] = '{16, OB};

    // Reference: qualified events per interval, reduced to a scaler only at pps.
    int cnt     [2][4];
    bit prev    [2][4];
    int exp_sc  [2][4];
    bit exp_sat [2][4];
    int exp_so  [2];
    bit exp_done[2];
    bit first = 1'b1;

    int nvec = 0;
    int nfail = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic logic [31:0] so_act(int d);
        return (d == 0) ? 32'(ifa.scaler_o) : 32'(ifb.scaler_o);
    endfunction

    function automatic logic sat_act(int d, int n);
        return (d == 0) ? ifa.sat_o[n] : ifb.sat_o[n];
    endfunction

    function automatic logic done_act(int d);
        return (d == 0) ? ifa.pps_done_o : ifb.pps_done_o;
    endfunction

    function automatic void latch(int d, int n);
        longint t    = longint'(cnt[d][n]) >> pre[d];
        longint amax = (longint'(1) << accb[d]) - 1;
        longint a    = (t > amax) ? amax : t;
        if (a >= (longint'(1) << (lsb[d] + ob[d]))) begin
            exp_sc[d][n]  = (1 << ob[d]) - 1;
            exp_sat[d][n] = 1'b1;
        end else begin
            exp_sc[d][n]  = int'(a >> lsb[d]);
            exp_sat[d][n] = 1'b0;
        end
    endfunction

    task automatic step();
        bit q;
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            exp_so[d]   = (rst || rd_v[d] >= nch[d]) ? 0 : exp_sc[d][rd_v[d]];
            exp_done[d] = !rst && pps_v[d];
            for (int n = 0; n < nch[d]; n++) begin
                if (rst) begin
                    cnt[d][n] = 0; prev[d][n] = 1'b0;
                    exp_sc[d][n] = 0; exp_sat[d][n] = 1'b0;
                end else begin
                    q = dead_v[d][n] && (!mode_v[d][n] || (!prev[d][n] && !first));
                    if (pps_v[d]) begin
                        latch(d, n);
                        cnt[d][n] = 0;
                    end else if (q) begin
                        cnt[d][n]++;
                    end
                    prev[d][n] = dead_v[d][n];
                end
            end
        end
        first = rst;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("model_scaler_o[%0d]", d), so_act(d), 32'(exp_so[d]));
            chk($sformatf("model_pps_done[%0d]", d), 32'(done_act(d)), 32'(exp_done[d]));
            for (int n = 0; n < nch[d]; n++)
                chk($sformatf("model_sat[%0d][%0d]", d, n), 32'(sat_act(d, n)), 32'(exp_sat[d][n]));
        end
    endtask

    typedef struct {
        int d; int ch; bit mode; int hi; int lo; int reps;
        bit pps_last; bit clr; int exp_sc; bit exp_sat;
    } vec_t;
    vec_t vecs [7];

    task automatic run_vec(int id, vec_t v);
        mode_v[v.d][v.ch] = v.mode;
        rd_v[v.d] = v.ch;
        if (v.clr) begin
            pps_v[v.d] = 1'b1; step();
            pps_v[v.d] = 1'b0; step();
        end
        for (int r = 0; r < v.reps; r++) begin
            for (int i = 0; i < v.hi; i++) begin
                dead_v[v.d][v.ch] = 1'b1;
                pps_v[v.d] = v.pps_last && (r == v.reps - 1) && (i == v.hi - 1);
                step();
            end
            for (int i = 0; i < v.lo; i++) begin
                dead_v[v.d][v.ch] = 1'b0;
                step();
            end
        end
        dead_v[v.d][v.ch] = 1'b0;
        if (!v.pps_last) begin
            pps_v[v.d] = 1'b1; step();
        end
        pps_v[v.d] = 1'b0;
        chk($sformatf("vec%0d_done_hi", id), 32'(done_act(v.d)), 32'd1);
        step();
        chk($sformatf("vec%0d_done_lo", id), 32'(done_act(v.d)), 32'd0);
        chk($sformatf("vec%0d_scaler", id), so_act(v.d), 32'(v.exp_sc));
        chk($sformatf("vec%0d_sat", id), 32'(sat_act(v.d, v.ch)), 32'(v.exp_sat));
    endtask

    initial begin
        vecs[0] = '{d:0, ch:0, mode:0, hi:2048, lo:0, reps:1,    pps_last:0, clr:1, exp_sc:1,  exp_sat:0};
        vecs[1] = '{d:0, ch:0, mode:0, hi:2048, lo:0, reps:1,    pps_last:1, clr:1, exp_sc:0,  exp_sat:0};
        vecs[2] = '{d:0, ch:0, mode:0, hi:2016, lo:0, reps:1,    pps_last:0, clr:0, exp_sc:0,  exp_sat:0};
        vecs[3] = '{d:0, ch:1, mode:1, hi:1,    lo:1, reps:4096, pps_last:0, clr:1, exp_sc:2,  exp_sat:0};
        vecs[4] = '{d:0, ch:1, mode:0, hi:2,    lo:1, reps:4096, pps_last:0, clr:1, exp_sc:4,  exp_sat:0};
        vecs[5] = '{d:1, ch:0, mode:0, hi:200,  lo:0, reps:1,    pps_last:0, clr:1, exp_sc:15, exp_sat:1};
        vecs[6] = '{d:1, ch:0, mode:0, hi:4,    lo:0, reps:1,    pps_last:0, clr:0, exp_sc:1,  exp_sat:0};

        for (int d = 0; d < 2; d++) begin
            dead_v[d] = '0; mode_v[d] = '0; pps_v[d] = 1'b0; rd_v[d] = 0;
            for (int n = 0; n < 4; n++) begin
                cnt[d][n] = 0; prev[d][n] = 1'b0; exp_sc[d][n] = 0; exp_sat[d][n] = 1'b0;
            end
        end
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("rst_scaler_a", so_act(0), 32'd0);
        chk("rst_sat_a", 32'(ifa.sat_o), 32'd0);
        chk("rst_done_a", 32'(done_act(0)), 32'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset with a coincident pps: nothing latched, no done pulse.
        dead_v[0][2] = 1'b1;
        repeat (100) step();
        rst = 1'b1; pps_v[0] = 1'b1; pps_v[1] = 1'b1;
        step();
        rst = 1'b0; pps_v[0] = 1'b0; pps_v[1] = 1'b0; dead_v[0][2] = 1'b0;
        chk("rstpps_done_a", 32'(done_act(0)), 32'd0);
        chk("rstpps_done_b", 32'(done_act(1)), 32'd0);
        chk("rstpps_sat_a", 32'(ifa.sat_o), 32'd0);
        chk("rstpps_sat_b", 32'(ifb.sat_o), 32'd0);
        for (int a = 0; a < 4; a++) begin
            rd_v[0] = a; rd_v[1] = a;
            step();
            chk($sformatf("rstpps_rd_a%0d", a), so_act(0), 32'd0);
            chk($sformatf("rstpps_rd_b%0d", a), so_act(1), 32'd0);
        end

        // A level already high across reset release must not count as an edge.
        mode_v[1][1] = 1'b1; dead_v[1][1] = 1'b1;
        rst = 1'b1; step(); step();
        rst = 1'b0; step();
        for (int k = 0; k < 3; k++) begin
            dead_v[1][1] = 1'b0; step();
            dead_v[1][1] = 1'b1; step();
        end
        dead_v[1][1] = 1'b0; pps_v[1] = 1'b1; step();
        pps_v[1] = 1'b0; rd_v[1] = 1; step();
        chk("edge_after_rst_scaler", so_act(1), 32'd0);
        chk("edge_after_rst_sat", 32'(sat_act(1, 1)), 32'd0);

        for (int c = 0; c < 12000; c++) begin
            for (int d = 0; d < 2; d++) begin
                for (int n = 0; n < 4; n++) begin
                    if ($urandom_range(0, 3) == 0) dead_v[d][n] = ~dead_v[d][n];
                    if ($urandom_range(0, 499) == 0) mode_v[d][n] = ~mode_v[d][n];
                end
                pps_v[d] = (d == 0) ? ($urandom_range(0, 2499) == 0) : ($urandom_range(0, 59) == 0);
                rd_v[d]  = int'($urandom_range(0, 3));
            end
            rst = ($urandom_range(0, 3999) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/anita_multi_deadtime_scaler.md
ANITA_MULTI_DEADTIME_SCALER -- requirements
Module: anita_multi_deadtime_scaler

Interface
REQ-001 Parameter NCH, default 4: number of independent deadtime channels (1..16).
REQ-002 Parameter PRESCALE_BITS, default 5: prescaler width; one accumulator tick per 2^PRESCALE_BITS qualified counts.
REQ-003 Parameter ACC_BITS, default 23: per-channel accumulator width.
REQ-004 Parameter OUT_BITS, default 16: reported scaler width.
REQ-005 Parameter OUT_LSB, default 6: accumulator bit mapped to scaler bit 0; OUT_LSB+OUT_BITS SHALL be <= ACC_BITS (elaboration error otherwise).
REQ-006 clk33_i  input  1  sole clock; all logic on its rising edge.
REQ-007 rst_i  input  1  synchronous, active-high reset.
REQ-008 dead_i  input  NCH  per-channel dead/busy level, synchronous to clk33_i.
REQ-009 pps_i  input  1  one-cycle pulse marking the end of a one-second interval.
REQ-010 mode_i  input  NCH  per-channel mode: 0 = count cycles with dead high, 1 = count dead rising edges.
REQ-011 rd_addr_i  input  max(1,clog2(NCH))  channel select for readback.
REQ-012 scaler_o  output  OUT_BITS  latched scaler of selected channel, registered.
REQ-013 sat_o  output  NCH  per-channel flag: latched value clamped at last pps.
REQ-014 pps_done_o  output  1  one-cycle pulse, cycle after pps_i, when new scalers are valid.

Function
REQ-015 Qualified count per channel: mode 0 -> dead_i[n]=1 this cycle; mode 1 -> dead_i[n]=1 and dead_q[n]=0 (dead_q = dead_i registered one cycle).
REQ-016 dead_q SHALL update every cycle, including pps cycles, so no spurious edge arises across a pps boundary.
REQ-017 Prescaler[n] (PRESCALE_BITS wide) SHALL increment on each qualified count; wrap from all-ones to zero produces one accumulator tick.
REQ-018 Accumulator[n] SHALL increment on a tick and hold at all-ones (saturate, never wrap).
REQ-019 On pps_i: scaler[n] <= acc[n][OUT_LSB+OUT_BITS-1:OUT_LSB], except scaler[n] <= all-ones and sat_o[n] <= 1 when any acc[n] bit above OUT_LSB+OUT_BITS-1 is set; otherwise sat_o[n] <= 0.
REQ-020 On pps_i the prescaler and accumulator of every channel SHALL clear; a qualified count coinciding with pps_i is discarded (pps wins).
REQ-021 Latched value uses acc[n] as held before the pps edge (the count from the pps cycle is excluded).
REQ-022 mode_i changes take effect on the next cycle's qualification; prescaler/accumulator are not cleared by a mode change.
REQ-023 scaler_o SHALL equal scaler[rd_addr_i] one cycle after rd_addr_i is presented; rd_addr_i >= NCH yields zero.
REQ-024 pps_done_o SHALL assert exactly the cycle after pps_i; back-to-back pps_i pulses produce back-to-back pps_done_o pulses.
REQ-025 Channels SHALL be fully independent; activity on one channel never affects another's counts.

Reset
REQ-026 rst_i SHALL clear prescalers, accumulators, dead_q, scalers, sat_o, scaler_o and pps_done_o to 0 on the next clock edge.
REQ-027 rst_i takes priority over pps_i; pps_i coincident with rst_i produces no latch and no pps_done_o.
REQ-028 After rst_i deasserts, counting resumes the next cycle; a dead_i already high is not counted as an edge (dead_q reset to 0 is overridden: first cycle after reset loads dead_q only, no edge counted).

Verification
REQ-029 Defaults, ch0 mode 0, dead_i[0] high 2048 cycles, then pps_i -> scaler[0]=1, sat_o[0]=0, other channels 0, pps_done_o one cycle after pps_i.
REQ-030 Defaults, ch1 mode 1, 4096 single-cycle dead pulses (dead low between), pps_i -> scaler[1]=2; same stimulus in mode 0 with 2-cycle pulses -> scaler[1]=4.
REQ-031 Bench params PRESCALE_BITS=1, ACC_BITS=6, OUT_LSB=1, OUT_BITS=4, dead_i[0] high 200 cycles, pps_i -> scaler[0]=4'hF, sat_o[0]=1; next interval 4 cycles high -> scaler[0]=1, sat_o[0]=0.
REQ-032 Qualified count on the pps_i cycle (dead high exactly 2048 cycles, last one coincident with pps_i) -> scaler[0]=0, next interval starts from zero.
REQ-033 rst_i asserted mid-interval with pps_i coincident -> all scalers 0, sat_o=0, no pps_done_o; rd_addr_i=NCH -> scaler_o=0 next cycle.
